// File: rtl/uart_pkg.sv
// Shared UART parameters used by uart_rx, uart_tx and the receive FIFO.
package uart_pkg;
  localparam int UART_DATA_W     = 8;
  localparam int UART_FIFO_DEPTH = 16;
  localparam int UART_FIFO_AFULL = 12;

  function automatic int fifo_cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction
endpackage

// File: rtl/uart_fifo_mem.sv
// Receive FIFO storage: register array, synchronous write, asynchronous read.
module uart_fifo_mem
  import uart_pkg::*;
#(
  parameter int DATA_W = UART_DATA_W,
  parameter int DEPTH  = UART_FIFO_DEPTH
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [DATA_W-1:0]        wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [DATA_W-1:0]        rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Contents are deliberately not reset; the FIFO masks them while empty.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/uart_rx_fifo.sv
// First-word-fall-through FIFO behind uart_rx with edge-detected writes and sticky overflow.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DATA_W    = UART_DATA_W,
  parameter int DEPTH     = UART_FIFO_DEPTH,
  parameter int AFULL_LVL = UART_FIFO_AFULL
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   rx_done,
  input  logic [DATA_W-1:0]      data_in,
  input  logic                   rd_en,
  output logic [DATA_W-1:0]      rd_data,
  output logic                   empty,
  output logic                   full,
  output logic                   almost_full,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow,
  input  logic                   ovf_clr
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   CNT_ONE = {{AW{1'b0}}, 1'b1};
  localparam logic [AW-1:0] PTR_ONE = {{(AW-1){1'b0}}, 1'b1};
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_AFULL = (AW+1)'(AFULL_LVL);

  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [AW:0]       occ;
  logic              rx_done_q;
  logic              armed;
  logic              ovf;
  logic [DATA_W-1:0] mem_rdata;
  logic              wr_stb;
  logic              pop;
  logic              wr_acc;
  logic              drop;

  // armed stays low until rx_done is seen low, so a level held across reset release is not a new byte
  assign wr_stb = rx_done & ~rx_done_q & armed;
  assign pop    = rd_en & ~empty;
  assign wr_acc = wr_stb & (~full | pop);
  assign drop   = wr_stb & full & ~pop;

  assign empty       = (occ == '0);
  assign full        = (occ == CNT_FULL);
  assign almost_full = (occ >= CNT_AFULL);
  assign count       = occ;
  assign overflow    = ovf;
  assign rd_data     = empty ? '0 : mem_rdata;

  // Pointer, occupancy, edge-detect and overflow state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      occ       <= '0;
      rx_done_q <= 1'b0;
      armed     <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      rx_done_q <= rx_done;
      armed     <= armed | ~rx_done;
      if (wr_acc) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      case ({wr_acc, pop})
        2'b10:   occ <= occ + CNT_ONE;
        2'b01:   occ <= occ - CNT_ONE;
        default: occ <= occ;
      endcase
      ovf <= drop | (ovf & ~ovf_clr);
    end
  end

  uart_fifo_mem #(
    .DATA_W(DATA_W),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk  (clk),
    .we   (wr_acc),
    .waddr(wr_ptr),
    .wdata(data_in),
    .raddr(rd_ptr),
    .rdata(mem_rdata)
  );

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo against a queue-based reference model.
module tb_uart_rx_fifo;
  localparam int DEPTH = 16;
  localparam int AFULL = 12;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       rx_done = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic       rd_en = 1'b0;
  logic       ovf_clr = 1'b0;
  logic [7:0] rd_data;
  logic       empty, full, almost_full, overflow;
  logic [4:0] count;

  int errors = 0;
  int checks = 0;

  logic [7:0] m_q[$];
  logic       m_ovf = 1'b0;

  uart_rx_fifo dut (
    .clk(clk), .reset(reset), .rx_done(rx_done), .data_in(data_in), .rd_en(rd_en),
    .rd_data(rd_data), .empty(empty), .full(full), .almost_full(almost_full),
    .count(count), .overflow(overflow), .ovf_clr(ovf_clr)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Model: one byte offered to the FIFO, optionally with a pop in the same cycle.
  task automatic m_offer(input logic [7:0] d, input bit with_pop);
    bit popped;
    bit had_room;
    had_room = (m_q.size() < DEPTH);
    popped = with_pop && (m_q.size() > 0);
    if (popped) void'(m_q.pop_front());
    if (had_room || popped) m_q.push_back(d);
    else m_ovf = 1'b1;
  endtask

  task automatic send(input logic [7:0] d, input int len);
    data_in = d;
    rx_done = 1'b1;
    repeat (len) tick();
    rx_done = 1'b0;
    data_in = $urandom_range(0, 255);
    m_offer(d, 1'b0);
    tick();
  endtask

  task automatic send_pop(input logic [7:0] d);
    data_in = d;
    rx_done = 1'b1;
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    rx_done = 1'b0;
    m_offer(d, 1'b1);
    tick();
  endtask

  task automatic pop();
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    if (m_q.size() > 0) void'(m_q.pop_front());
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) tick();
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty got=%b exp=1", empty); end
    checks++; if (count !== 5'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", count); end
    checks++; if ({full, almost_full, overflow} !== 3'b000) begin errors++; $display("FAIL reset_flags got=%b exp=000", {full, almost_full, overflow}); end
    checks++; if (rd_data !== 8'h00) begin errors++; $display("FAIL reset_rd_data got=%h exp=00", rd_data); end
    reset = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_single();
    send(8'h55, 3);
    checks++; if (count !== 5'd1) begin errors++; $display("FAIL single_count got=%0d exp=1", count); end
    checks++; if (rd_data !== 8'h55) begin errors++; $display("FAIL single_rd_data got=%h exp=55", rd_data); end
    pop();
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL single_empty got=%b exp=1", empty); end
    checks++; if (rd_data !== 8'h00) begin errors++; $display("FAIL single_rd_zero got=%h exp=00", rd_data); end
  endtask

  task automatic test_fill();
    for (int i = 0; i < 16; i++) begin
      send(8'(i), 1 + (i % 2));
      checks++; if (almost_full !== (i + 1 >= AFULL)) begin errors++; $display("FAIL fill_afull n=%0d got=%b", i + 1, almost_full); end
      checks++; if (full !== (i + 1 == DEPTH)) begin errors++; $display("FAIL fill_full n=%0d got=%b", i + 1, full); end
    end
    send(8'hAA, 1);
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL fill_overflow got=%b exp=1", overflow); end
    checks++; if (count !== 5'd16) begin errors++; $display("FAIL fill_count got=%0d exp=16", count); end
    for (int i = 0; i < 16; i++) begin
      checks++; if (rd_data !== 8'(i)) begin errors++; $display("FAIL fill_order idx=%0d got=%h exp=%h", i, rd_data, 8'(i)); end
      pop();
    end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL fill_drained got=%b exp=1", empty); end
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    m_ovf = 1'b0;
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_clear got=%b exp=0", overflow); end
  endtask

  task automatic test_full_rw();
    for (int i = 0; i < 16; i++) send(8'($urandom_range(0, 255)), 1);
    send_pop(8'h77);
    checks++; if (count !== 5'd16) begin errors++; $display("FAIL fullrw_count got=%0d exp=16", count); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL fullrw_overflow got=%b exp=0", overflow); end
    while (m_q.size() > 0) begin
      checks++; if (rd_data !== m_q[0]) begin errors++; $display("FAIL fullrw_data left=%0d got=%h exp=%h", m_q.size(), rd_data, m_q[0]); end
      if (m_q.size() == 1) begin
        checks++; if (rd_data !== 8'h77) begin errors++; $display("FAIL fullrw_last got=%h exp=77", rd_data); end
      end
      pop();
    end
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 10; i++) send(8'($urandom_range(0, 255)), 1);
    for (int i = 0; i < 10; i++) pop();
    for (int i = 0; i < 10; i++) send(8'hC0 + 8'(i), 2);
    for (int i = 0; i < 10; i++) begin
      checks++; if (rd_data !== 8'hC0 + 8'(i)) begin errors++; $display("FAIL wrap_data idx=%0d got=%h exp=%h", i, rd_data, 8'hC0 + 8'(i)); end
      pop();
    end
  endtask

  task automatic test_empty_corner();
    send_pop(8'h3C);
    checks++; if (count !== 5'd1) begin errors++; $display("FAIL corner_count got=%0d exp=1", count); end
    checks++; if (rd_data !== 8'h3C) begin errors++; $display("FAIL corner_rd_data got=%h exp=3c", rd_data); end
    pop();
    for (int i = 0; i < 17; i++) send(8'($urandom_range(0, 255)), 1);
    data_in = 8'h99;
    rx_done = 1'b1;
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    rx_done = 1'b0;
    m_offer(8'h99, 1'b0);
    tick();
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL corner_set_wins got=%b exp=1", overflow); end
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    m_ovf = 1'b0;
    while (m_q.size() > 0) pop();
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 5; i++) send(8'($urandom_range(0, 255)), 1);
    @(posedge clk);
    #3;
    reset = 1'b1;
    rx_done = 1'b1;
    data_in = 8'hE5;
    #1;
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL rstmid_empty got=%b exp=1", empty); end
    checks++; if (count !== 5'd0) begin errors++; $display("FAIL rstmid_count got=%0d exp=0", count); end
    #10;
    reset = 1'b0;
    m_q.delete();
    m_ovf = 1'b0;
    repeat (4) tick();
    checks++; if (count !== 5'd0) begin errors++; $display("FAIL rstmid_no_write got=%0d exp=0", count); end
    rx_done = 1'b0;
    tick();
    send(8'h5A, 1);
    checks++; if (rd_data !== 8'h5A) begin errors++; $display("FAIL rstmid_after got=%h exp=5a", rd_data); end
    pop();
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      case ($urandom_range(0, 3))
        0, 1: send(8'($urandom_range(0, 255)), $urandom_range(1, 3));
        2: pop();
        default: send_pop(8'($urandom_range(0, 255)));
      endcase
      if ($urandom_range(0, 15) == 0) begin
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        m_ovf = 1'b0;
      end
      checks++; if (count !== 5'(m_q.size())) begin errors++; $display("FAIL rand_count n=%0d got=%0d exp=%0d", n, count, m_q.size()); end
      checks++; if (rd_data !== ((m_q.size() > 0) ? m_q[0] : 8'h00)) begin errors++; $display("FAIL rand_rd_data n=%0d got=%h", n, rd_data); end
      checks++; if ({empty, full, almost_full} !== {m_q.size() == 0, m_q.size() == DEPTH, m_q.size() >= AFULL}) begin errors++; $display("FAIL rand_flags n=%0d got=%b", n, {empty, full, almost_full}); end
      checks++; if (overflow !== m_ovf) begin errors++; $display("FAIL rand_overflow n=%0d got=%b exp=%b", n, overflow, m_ovf); end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill();
    test_full_rw();
    test_wrap();
    test_empty_corner();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
